// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with a busy scoreboard.
//
// The decode stage reads up to NUM_READ operands and reserves a destination.
// Writeback writes one result per cycle and clears that register's busy bit.
// Read data and read-valid are registered with one cycle of latency.
//
// Ports:
//   clk             clock; all state updates on the rising edge
//   reset_enable    synchronous active-high reset, priority over everything
//   get_enable      capture all read ports this cycle
//   get_num         read addresses, port k at [k*REG_FILE_SIZE +: REG_FILE_SIZE]
//   out             registered read data, port k at [k*WORD_SIZE +: WORD_SIZE]
//   out_valid       port k data is not waiting on an outstanding reservation
//   set_enable      write strobe
//   set_num         write address
//   set_val         write data
//   reserve_enable  mark reserve_num busy
//   reserve_num     register to reserve
//   busy            registered scoreboard, bit i = register i pending
module reg_file_mp #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned REG_FILE_SIZE  = 5,
    parameter int unsigned REG_STACK_SIZE = 32,
    parameter int unsigned NUM_READ       = 3,
    parameter int unsigned ZERO_REG       = 1
) (
    input  logic                              clk,
    input  logic                              reset_enable,
    input  logic                              get_enable,
    input  logic [NUM_READ*REG_FILE_SIZE-1:0] get_num,
    output logic [NUM_READ*WORD_SIZE-1:0]     out,
    output logic [NUM_READ-1:0]               out_valid,
    input  logic                              set_enable,
    input  logic [REG_FILE_SIZE-1:0]          set_num,
    input  logic [WORD_SIZE-1:0]              set_val,
    input  logic                              reserve_enable,
    input  logic [REG_FILE_SIZE-1:0]          reserve_num,
    output logic [REG_STACK_SIZE-1:0]         busy
);

    localparam int unsigned OUT_W = NUM_READ * WORD_SIZE;

    // Register storage and registered outputs
    logic [WORD_SIZE-1:0]      regs_q [REG_STACK_SIZE];
    logic [WORD_SIZE-1:0]      regs_d [REG_STACK_SIZE];
    logic [REG_STACK_SIZE-1:0] busy_q;
    logic [REG_STACK_SIZE-1:0] busy_d;
    logic [OUT_W-1:0]          out_q;
    logic [OUT_W-1:0]          out_d;
    logic [NUM_READ-1:0]       out_valid_q;
    logic [NUM_READ-1:0]       out_valid_d;

    // Qualified write/reserve strobes and per-port read scratch
    logic                      set_ok;
    logic                      reserve_ok;
    logic [REG_FILE_SIZE-1:0]  rd_addr;
    logic                      rd_hit;

    // An address names real, writable storage: in range and not the zero register.
    function automatic logic addr_writable(input logic [REG_FILE_SIZE-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = (32'(a) < REG_STACK_SIZE);
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    // Next-state: array write, scoreboard update, read capture with bypass
    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        rd_addr     = '0;
        rd_hit      = 1'b0;

        set_ok     = set_enable     && addr_writable(set_num);
        reserve_ok = reserve_enable && addr_writable(reserve_num);

        if (set_ok) begin
            regs_d[set_num] = set_val;
            busy_d[set_num] = 1'b0;
        end

        // Applied after the write so a same-cycle reservation wins.
        if (reserve_ok) begin
            busy_d[reserve_num] = 1'b1;
        end

        // Reads use the pre-edge scoreboard; only a same-cycle write clears the hazard.
        if (get_enable) begin
            for (int k = 0; k < int'(NUM_READ); k++) begin
                rd_addr = get_num[k*REG_FILE_SIZE +: REG_FILE_SIZE];
                rd_hit  = set_ok && (set_num == rd_addr);
                if (!addr_writable(rd_addr)) begin
                    out_d[k*WORD_SIZE +: WORD_SIZE] = '0;
                    out_valid_d[k]                  = 1'b1;
                end else begin
                    out_d[k*WORD_SIZE +: WORD_SIZE] = rd_hit ? set_val : regs_q[rd_addr];
                    out_valid_d[k]                  = !busy_q[rd_addr] || rd_hit;
                end
            end
        end
    end

    // State registers; reset discards every same-cycle request
    always_ff @(posedge clk) begin
        if (reset_enable) begin
            regs_q      <= '{default: '0};
            busy_q      <= '0;
            out_q       <= '0;
            out_valid_q <= '0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default parameters: 32x32, 3 read ports, zero reg).
// Read expectations are computed from a behavioural model when a read is issued,
// queued, and compared when the registered result appears one cycle later.
module tb_reg_file_mp;

    logic        clk;
    logic        reset_enable;
    logic        get_enable;
    logic [14:0] get_num;
    logic [95:0] out;
    logic [2:0]  out_valid;
    logic        set_enable;
    logic [4:0]  set_num;
    logic [31:0] set_val;
    logic        reserve_enable;
    logic [4:0]  reserve_num;
    logic [31:0] busy;

    reg_file_mp dut (
        .clk            (clk),
        .reset_enable   (reset_enable),
        .get_enable     (get_enable),
        .get_num        (get_num),
        .out            (out),
        .out_valid      (out_valid),
        .set_enable     (set_enable),
        .set_num        (set_num),
        .set_val        (set_val),
        .reserve_enable (reserve_enable),
        .reserve_num    (reserve_num),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [95:0] data;
        logic [2:0]  valid;
    } rd_exp_t;

    rd_exp_t     exp_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [95:0] m_out;
    logic [2:0]  m_valid;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, update the model, and check outputs after the edge.
    task automatic cycle(input logic rst, input logic get, input logic [14:0] gn,
                         input logic set, input logic [4:0] sn, input logic [31:0] sv,
                         input logic res, input logic [4:0] rn, input string tag);
        rd_exp_t e;
        logic [4:0] a;
        logic       wr_hit;
        reset_enable   = rst;
        get_enable     = get;
        get_num        = gn;
        set_enable     = set;
        set_num        = sn;
        set_val        = sv;
        reserve_enable = res;
        reserve_num    = rn;

        if (!rst && get) begin
            e = '0;
            for (int k = 0; k < 3; k++) begin
                a = gn[k*5 +: 5];
                wr_hit = set && (sn == a);
                if (a == 5'd0) begin
                    e.data[k*32 +: 32] = 32'h0;
                    e.valid[k]         = 1'b1;
                end else begin
                    e.data[k*32 +: 32] = wr_hit ? sv : m_regs[a];
                    e.valid[k]         = wr_hit | ~m_busy[a];
                end
            end
            exp_q.push_back(e);
        end

        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_busy  = 32'h0;
            m_out   = '0;
            m_valid = '0;
        end else begin
            if (set && sn != 5'd0) begin
                m_regs[sn]  = sv;
                m_busy[sn]  = 1'b0;
            end
            if (res && rn != 5'd0) m_busy[rn] = 1'b1;
        end

        @(posedge clk);
        #1;
        if (!rst && get) begin
            if (exp_q.size() == 0) begin
                check({tag, " queue"}, 128'd1, 128'd0);
            end else begin
                e       = exp_q.pop_front();
                m_out   = e.data;
                m_valid = e.valid;
            end
        end
        check({tag, " out"},       128'(out),       128'(m_out));
        check({tag, " out_valid"}, 128'(out_valid), 128'(m_valid));
        check({tag, " busy"},      128'(busy),      128'(m_busy));
    endtask

    function automatic logic [14:0] gn3(input logic [4:0] p2, input logic [4:0] p1,
                                        input logic [4:0] p0);
        return {p2, p1, p0};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy  = '0;
        m_out   = '0;
        m_valid = '0;
        reset_enable = 1'b1; get_enable = 1'b0; get_num = '0;
        set_enable = 1'b0; set_num = '0; set_val = '0;
        reserve_enable = 1'b0; reserve_num = '0;
        @(negedge clk);

        cycle(1, 0, '0, 0, 0, 0, 0, 0, "reset");

        // Write then read the same register on two ports plus r0
        cycle(0, 0, '0, 1, 5'd5, 32'h1234, 0, 0, "wr_r5");
        cycle(0, 1, gn3(5'd0, 5'd5, 5'd5), 0, 0, 0, 0, 0, "rd_r5");
        check("rd_r5 literal", 128'(out), 128'({32'h0, 32'h1234, 32'h1234}));

        // Same-cycle write bypasses into port 1
        cycle(0, 1, gn3(5'd0, 5'd7, 5'd1), 1, 5'd7, 32'hDEAD, 0, 0, "bypass_r7");
        check("bypass_r7 port1", 128'(out[63:32]), 128'(32'hDEAD));

        // Reservation hazard, then cleared by a same-cycle write
        cycle(0, 0, '0, 0, 0, 0, 1, 5'd3, "res_r3");
        cycle(0, 1, gn3(5'd3, 5'd3, 5'd3), 0, 0, 0, 0, 0, "rd_r3_busy");
        check("rd_r3_busy valid", 128'(out_valid), 128'(3'b000));
        cycle(0, 1, gn3(5'd3, 5'd3, 5'd3), 1, 5'd3, 32'h55, 0, 0, "wr_rd_r3");
        check("wr_rd_r3 valid", 128'(out_valid), 128'(3'b111));

        // Reserve wins over set; read in same cycle as reserve sees old scoreboard
        cycle(0, 1, gn3(5'd4, 5'd4, 5'd4), 1, 5'd4, 32'h9, 1, 5'd4, "res_set_r4");
        check("res_set_r4 busy4", 128'(busy[4]), 128'(1'b1));
        cycle(0, 1, gn3(5'd4, 5'd0, 5'd4), 0, 0, 0, 0, 0, "rd_r4");

        // Zero register ignores writes and reservations
        cycle(0, 0, '0, 1, 5'd0, 32'hFF, 1, 5'd0, "wr_r0");
        cycle(0, 1, gn3(5'd0, 5'd0, 5'd0), 0, 0, 0, 0, 0, "rd_r0");
        check("rd_r0 busy0", 128'(busy[0]), 128'(1'b0));

        // Fill, reserve, then reset with concurrent set/reserve/get
        for (int i = 1; i < 32; i++)
            cycle(0, 0, '0, 1, 5'(i), 32'hA000_0000 | 32'(i), 0, 0, "fill");
        cycle(0, 1, gn3(5'd31, 5'd2, 5'd1), 0, 0, 0, 1, 5'd2, "res_r2");
        cycle(1, 1, gn3(5'd9, 5'd2, 5'd1), 1, 5'd9, 32'h77, 1, 5'd6, "mid_reset");
        check("mid_reset out", 128'(out), 128'(0));
        cycle(0, 1, gn3(5'd31, 5'd2, 5'd9), 0, 0, 0, 0, 0, "post_reset_rd");

        // Hold: out stays put while the addressed register changes
        cycle(0, 0, '0, 1, 5'd6, 32'h600D, 0, 0, "wr_r6");
        cycle(0, 1, gn3(5'd6, 5'd6, 5'd6), 0, 0, 0, 0, 0, "rd_r6");
        cycle(0, 0, gn3(5'd6, 5'd6, 5'd6), 1, 5'd6, 32'hBAD0, 0, 0, "hold1");
        cycle(0, 0, gn3(5'd6, 5'd6, 5'd6), 1, 5'd6, 32'hBAD1, 1, 5'd6, "hold2");
        check("hold2 literal", 128'(out[31:0]), 128'(32'h600D));
        cycle(0, 1, gn3(5'd6, 5'd6, 5'd6), 0, 0, 0, 0, 0, "rd_r6_again");

        // Random mixed traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)),
                  15'($urandom), 1'($urandom_range(0, 1)), 5'($urandom),
                  $urandom, ($urandom_range(0, 9) < 3), 5'($urandom), "rand");
        end

        check("queue drained", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
